pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised pipeline control unit for the 5-stage core. It replaces the separate hazard and forwarding units with one block. It adds three things: a memory-wait state machine for a multi-cycle data memory, branch-flush arbitration against memory freezes, and saturating performance counters. It sits beside the stage registers in the top level, reads destination, source and enable fields from ID, ID/EX, EX/MEM and MEM/WB, and drives all freeze, flush and forwarding-select controls.

## Interface
- REG_AW, 4: register-index width.
- TIMEOUT, 255: maximum memory-wait cycles before the error flag sets.
- CNT_W, 16: performance-counter width.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- fwd_en  in  1  runtime forwarding enable; honoured only with PIPE_HAZARD_CTRL_FWD_EN.
- id_src1, id_src2  in  REG_AW  ID-stage source indices.
- id_two_src  in  1  ID instruction reads src2.
- ex_dest, mem_dest, wb_dest  in  REG_AW  destination indices in EX, MEM, WB.
- ex_wb_en, mem_wb_en, wb_wb_en  in  1  write-back enables in EX, MEM, WB.
- ex_mem_rd  in  1  EX instruction is a load.
- idex_src1, idex_src2  in  REG_AW  sources latched in ID/EX.
- mem_req  in  1  MEM stage issues a read or write.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  EX resolves a taken branch.
- freeze_front  out  1  hold PC and IF/ID (load-use or memory wait).
- bubble_idex  out  1  load NOP into ID/EX.
- hold_back  out  1  hold ID/EX, EX/MEM and MEM/WB (memory wait).
- flush_ifid, flush_idex  out  1  branch flushes.
- sel_src1, sel_src2  out  2  0 = register file, 1 = EX/MEM result, 2 = WB value.
- mem_err  out  1  sticky memory-timeout flag.
- cnt_stall, cnt_memwait, cnt_flush  out  CNT_W  performance counters.

## Operation
- mem_hold = mem_req & ~mem_ready.
- While mem_hold: hold_back = 1, freeze_front = 1, bubble_idex = 0, flush_* = 0. Memory wait overrides load-use and branch.
- Hazard match: a source equals a destination whose write-back enable is set. src2 is checked only when id_two_src = 1.
- Forwarding active: a load-use hazard exists when an ID source matches ex_dest with ex_wb_en & ex_mem_rd. It asserts freeze_front and bubble_idex.
- Forwarding inactive: any ID source match against EX or MEM asserts freeze_front and bubble_idex.
- Branch with no mem_hold: branch_taken drives flush_ifid = flush_idex = 1. freeze_front is suppressed; the flush wins over load-use.
- Forward selects, per source: 1 if it matches mem_dest with mem_wb_en; else 2 if it matches wb_dest with wb_wb_en; else 0. MEM has priority over WB. Selects are 0 when forwarding is inactive.
- FSM states:
  - IDLE → WAIT on mem_hold.
  - WAIT → IDLE on mem_ready.
  - WAIT → ERR when the wait counter reaches TIMEOUT.
  - ERR → IDLE on mem_ready; mem_err stays set.
- Wait counter: clears in IDLE and increments in WAIT. Width is clog2(TIMEOUT+1).
- Counters saturate at all-ones:
  - cnt_stall increments on cycles with bubble_idex.
  - cnt_memwait increments on cycles with mem_hold.
  - cnt_flush increments on cycles with flush_idex.
- Register index 0 is not special; all indices are forwardable.

## Timing
- Every control output is combinational from inputs in the same cycle; there is no added latency.
- FSM, wait counter, mem_err and the performance counters are registered on the rising edge of clk.
- Reset values:
  - state = IDLE
  - wait counter = 0
  - mem_err = 0
  - all counters = 0
- Reset mid-wait returns the FSM to IDLE immediately. Combinational outputs follow the inputs.
- mem_ready in the same cycle as the mem_req rising edge means no hold and no WAIT entry.
- A branch held during a memory wait stays in ID/EX. The flush fires in the cycle mem_hold drops.
- The timeout check is wait counter == TIMEOUT; it transitions to ERR on that edge.

## Configuration
- PIPE_HAZARD_CTRL_FWD_EN defined: the forwarding comparators exist, and fwd_en selects at runtime between forwarding and full-stall behaviour.
- PIPE_HAZARD_CTRL_FWD_EN undefined: sel_src1 = sel_src2 = 0 constantly, fwd_en is ignored, and hazard detection always uses full-stall rules.

## Structure
- The shared package holds:
  - forward-select encodings SEL_RF = 0, SEL_MEM = 1, SEL_WB = 2
  - the FSM state enum IDLE, WAIT, ERR
  - the default REG_AW
- One sub-module, pipe_sat_counter (CNT_W parameter, inc input, count output), is instantiated three times.

## Test plan
- idex_src1 = 3, mem_dest = 3, mem_wb_en = 1, wb_dest = 3, wb_wb_en = 1, fwd on → sel_src1 = 1; drop mem_wb_en → sel_src1 = 2.
- id_src2 = 5, id_two_src = 1, ex_dest = 5, ex_wb_en = 1, ex_mem_rd = 1, fwd on → freeze_front = 1, bubble_idex = 1, cnt_stall +1. Set id_two_src = 0 → no stall.
- Same stimulus with ex_mem_rd = 0 and fwd off → stall; with fwd on → no stall.
- mem_req = 1, mem_ready low for 4 cycles → hold_back high for 4 cycles, cnt_memwait = 4, state returns to IDLE, mem_err = 0.
- TIMEOUT = 8, mem_ready low for 12 cycles → ERR after 8 WAIT cycles, mem_err = 1 and it stays set after mem_ready and after further accesses, until rst is low.
- branch_taken during a 3-cycle memory wait → flushes stay 0 for 3 cycles, then flush_ifid = flush_idex = 1 for one cycle, cnt_flush = 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//   - Forward-select encodings driven on sel_src1 / sel_src2.
//   - Memory-wait FSM state type.
//   - Default register-index width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 4;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memState_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used for the pipeline performance statistics.
// Ports:
//   clk   - clock
//   rst   - asynchronous reset, active-low
//   inc   - count one event this cycle
//   count - running total, sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit for the 5-stage core: load-use / full-stall hazard
// detection, forwarding selects, multi-cycle data-memory wait handling with a
// timeout flag, branch flush arbitration and saturating performance counters.
//
// Build option: PIPE_HAZARD_CTRL_FWD_EN
//   defined   - forwarding comparators are built; fwd_en chooses at runtime
//               between forwarding and full-stall behaviour.
//   undefined - selects are tied to the register file, fwd_en is ignored and
//               hazard detection always uses full-stall rules.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   fwd_en                    runtime forwarding enable
//   id_src1/2, id_two_src     ID-stage sources, src2 valid flag
//   ex/mem/wb_dest, *_wb_en   destinations and write-back enables
//   ex_mem_rd                 EX instruction is a load
//   idex_src1/2               sources latched in ID/EX (forwarding)
//   mem_req, mem_ready        data-memory handshake
//   branch_taken              taken branch resolved in EX
//   freeze_front, bubble_idex, hold_back, flush_ifid, flush_idex
//   sel_src1/2                forwarding selects (SEL_RF/SEL_MEM/SEL_WB)
//   mem_err                   sticky memory-timeout flag
//   cnt_stall/memwait/flush   saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              ex_wb_en,
  input  logic              mem_wb_en,
  input  logic              wb_wb_en,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] idex_src1,
  input  logic [REG_AW-1:0] idex_src2,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              freeze_front,
  output logic              bubble_idex,
  output logic              hold_back,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic              mem_err,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_memwait,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  function automatic logic srcHit(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst,
                                  input logic              wbEn);
    return wbEn && (src == dst);
  endfunction

  logic      memHold;
  logic      fwdActive;
  logic      exHit;
  logic      memHit;
  logic      hazard;
  memState_t state;
  memState_t stateNext;
  logic [WCNT_W-1:0] waitCnt;

  assign memHold = mem_req & ~mem_ready;

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (srcHit(src, mem_dest, mem_wb_en)) return SEL_MEM;
    if (srcHit(src, wb_dest, wb_wb_en))   return SEL_WB;
    return SEL_RF;
  endfunction

  assign fwdActive = fwd_en;
  assign sel_src1  = fwdActive ? fwdSel(idex_src1) : SEL_RF;
  assign sel_src2  = fwdActive ? fwdSel(idex_src2) : SEL_RF;
`else
  // Forwarding hardware is absent in this build; these inputs are unused.
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{fwd_en, wb_dest, wb_wb_en, idex_src1, idex_src2};
  assign fwdActive = 1'b0;
  assign sel_src1  = SEL_RF;
  assign sel_src2  = SEL_RF;
`endif

  // src2 only participates when the ID instruction actually reads it.
  assign exHit  = srcHit(id_src1, ex_dest, ex_wb_en) |
                  (id_two_src & srcHit(id_src2, ex_dest, ex_wb_en));
  assign memHit = srcHit(id_src1, mem_dest, mem_wb_en) |
                  (id_two_src & srcHit(id_src2, mem_dest, mem_wb_en));

  // With forwarding only a load in EX cannot be bypassed; without it any
  // in-flight producer in EX or MEM forces a stall.
  assign hazard = fwdActive ? (exHit & ex_mem_rd) : (exHit | memHit);

  // Priority: memory wait freezes everything, then a taken branch flushes
  // (the wrong-path instruction in ID is discarded, so no load-use stall),
  // then the data hazard.
  always_comb begin
    hold_back    = 1'b0;
    freeze_front = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    if (memHold) begin
      hold_back    = 1'b1;
      freeze_front = 1'b1;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hazard) begin
      freeze_front = 1'b1;
      bubble_idex  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A completion in WAIT takes priority over a coincident timeout.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (memHold) stateNext = WAIT;
      WAIT: begin
        if (mem_ready) begin
          stateNext = IDLE;
        end else if (waitCnt == WCNT_W'(TIMEOUT)) begin
          stateNext = ERR;
        end
      end
      ERR:     if (mem_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt + 1'b1;
    end else begin
      waitCnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if ((state == WAIT) && (stateNext == ERR)) begin
      mem_err <= 1'b1;
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_idex),
    .count (cnt_stall)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) uMemWaitCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (memHold),
    .count (cnt_memwait)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_idex),
    .count (cnt_flush)
  );

endmodule
